fir_stream_driver: RTL and testbench

FIR_STREAM_DRIVER -- requirements
Module: fir_stream_driver

---
 rtl/fir_stream_driver.sv | 267 ++++++++++++++++++++++++++
 tb/tb_fir_stream_driver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_driver.sv
// fir_stream_driver
// ---------------------------------------------------------------------------
// Streams upstream samples into an external FIR filter one at a time and
// forwards each filter result downstream over a valid/ready handshake.
//
// Samples are buffered in a small FIFO. A four-state controller pops the
// FIFO head, strobes it into the filter for one cycle, then waits for the
// filter result. A bounded wait guards against a filter that never answers.
// The captured result is held until the downstream side accepts it.
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous, active-high reset
//   s_data        upstream sample                        (InputWidth)
//   s_valid       upstream sample present
//   s_ready       FIFO has room for a sample
//   inputValid    one-cycle strobe: FIR_input is valid for the filter
//   FIR_input     sample presented to the filter          (InputWidth)
//   outputValid   filter result strobe
//   FIR_output    filter result                           (OutputWidth)
//   m_data        captured result to downstream           (OutputWidth)
//   m_valid       m_data valid
//   m_ready       downstream accepts m_data
//   timeout_err   sticky: a sample got no result within TimeoutCycles
//   sample_count  number of results delivered downstream  (32, wraps)
// ---------------------------------------------------------------------------
module fir_stream_driver #(
  parameter int InputWidth    = 16,
  parameter int OutputWidth   = 38,
  parameter int FifoDepth     = 8,
  parameter int TimeoutCycles = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InputWidth-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   inputValid,
  output logic [InputWidth-1:0]  FIR_input,
  input  logic                   outputValid,
  input  logic [OutputWidth-1:0] FIR_output,
  output logic [OutputWidth-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   timeout_err,
  output logic [31:0]            sample_count
);

  // Pointer width, occupancy width (one extra bit to represent "full"),
  // and timeout counter width.
  localparam int PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TimeoutCycles + 1);

  localparam logic [CW-1:0] DEPTH_C        = CW'(FifoDepth);
  localparam logic [CW-1:0] CNT_ONE_C      = CW'(1);
  localparam logic [PW-1:0] PTR_ONE_C      = PW'(1);
  localparam logic [TW-1:0] TMO_ONE_C      = TW'(1);
  // The counter holds the number of WAIT cycles already spent; the cycle in
  // which it equals TimeoutCycles-1 is the last permitted WAIT cycle.
  localparam logic [TW-1:0] TIMEOUT_LAST_C = TW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [InputWidth-1:0]  mem_r [FifoDepth];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [CW-1:0]          count_r;
  logic                   push_s;
  logic                   pop_s;
  logic                   fifo_empty_s;

  logic [TW-1:0]          wait_cnt_r;
  logic                   capture_s;
  logic                   timeout_s;
  logic                   deliver_s;
  logic                   load_s;

  logic                   input_valid_r;
  logic [InputWidth-1:0]  fir_input_r;
  logic [OutputWidth-1:0] m_data_r;
  logic                   m_valid_r;
  logic                   timeout_err_r;
  logic [31:0]            sample_count_r;

  // s_ready depends only on occupancy, never on a same-cycle pop.
  assign s_ready      = (count_r < DEPTH_C);
  assign push_s       = s_valid && s_ready;
  assign pop_s        = (state_r == ISSUE);
  assign fifo_empty_s = (count_r == '0);
  // FIR_input is captured on the IDLE->ISSUE edge, so the register already
  // holds the head while inputValid is high.
  assign load_s       = (state_r == IDLE) && (state_next_s == ISSUE);

  assign inputValid   = input_valid_r;
  assign FIR_input    = fir_input_r;
  assign m_data       = m_data_r;
  assign m_valid      = m_valid_r;
  assign timeout_err  = timeout_err_r;
  assign sample_count = sample_count_r;

  // FIFO storage: data words carry no reset, they are only read when valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FifoDepth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Controller next-state and event decode.
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    timeout_s    = 1'b0;
    deliver_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        state_next_s = WAIT;
      end
      WAIT: begin
        // A result on the last permitted cycle still wins over the timeout.
        if (outputValid) begin
          capture_s    = 1'b1;
          state_next_s = HOLD;
        end else if (wait_cnt_r == TIMEOUT_LAST_C) begin
          timeout_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      HOLD: begin
        if (m_ready) begin
          deliver_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // WAIT-cycle counter: cleared on issue, advanced each unanswered WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (state_r == ISSUE) begin
      wait_cnt_r <= '0;
    end else if ((state_r == WAIT) && !capture_s && !timeout_s) begin
      wait_cnt_r <= wait_cnt_r + TMO_ONE_C;
    end else if (timeout_s) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Strobe and valid outputs are registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_valid_r <= 1'b0;
      m_valid_r     <= 1'b0;
    end else begin
      input_valid_r <= (state_next_s == ISSUE);
      m_valid_r     <= (state_next_s == HOLD);
    end
  end

  // Sample register presented to the filter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fir_input_r <= '0;
    end else if (load_s) begin
      fir_input_r <= mem_r[rd_ptr_r];
    end else begin
      fir_input_r <= fir_input_r;
    end
  end

  // Result capture: only a strobe seen in WAIT updates m_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_r <= '0;
    end else if (capture_s) begin
      m_data_r <= FIR_output;
    end else begin
      m_data_r <= m_data_r;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_s) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

  // Delivered-result counter, wraps at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_count_r <= 32'd0;
    end else if (deliver_s) begin
      sample_count_r <= sample_count_r + 32'd1;
    end else begin
      sample_count_r <= sample_count_r;
    end
  end

endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed testbench for fir_stream_driver. Inputs change 1 time unit after
// each rising edge; outputs are sampled at that same point.
module tb_fir_stream_driver;

  logic        clk;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        inputValid;
  logic [15:0] FIR_input;
  logic        outputValid;
  logic [37:0] FIR_output;
  logic [37:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        timeout_err;
  logic [31:0] sample_count;

  int compared;
  int mismatched;

  fir_stream_driver dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .inputValid   (inputValid),
    .FIR_input    (FIR_input),
    .outputValid  (outputValid),
    .FIR_output   (FIR_output),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .timeout_err  (timeout_err),
    .sample_count (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_data = 16'h0; s_valid = 1'b0; outputValid = 1'b0;
    FIR_output = 38'h0; m_ready = 1'b0;
    tick; tick;
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    compared++; if (inputValid !== 1'b0) begin mismatched++; $display("FAIL reset_inputValid got %b want 0", inputValid); end
    compared++; if (FIR_input !== 16'h0) begin mismatched++; $display("FAIL reset_FIR_input got %h want 0", FIR_input); end
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    compared++; if (m_data !== 38'h0) begin mismatched++; $display("FAIL reset_m_data got %h want 0", m_data); end
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
    compared++; if (sample_count !== 32'd0) begin mismatched++; $display("FAIL reset_sample_count got %0d want 0", sample_count); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    s_data = 16'h0005; s_valid = 1'b1;
    tick;                                   // cycle n+1
    s_valid = 1'b0;
    compared++; if (inputValid !== 1'b0) begin mismatched++; $display("FAIL single_iv_n1 got %b want 0", inputValid); end
    tick;                                   // cycle n+2: ISSUE
    compared++; if (inputValid !== 1'b1) begin mismatched++; $display("FAIL single_iv_n2 got %b want 1", inputValid); end
    compared++; if (FIR_input !== 16'h0005) begin mismatched++; $display("FAIL single_fir_input got %h want 0005", FIR_input); end
    tick;                                   // n+3: WAIT
    compared++; if (inputValid !== 1'b0) begin mismatched++; $display("FAIL single_iv_n3 got %b want 0", inputValid); end
    tick; tick;                             // n+5
    outputValid = 1'b1; FIR_output = 38'h19; m_ready = 1'b1;
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL single_mv_wait got %b want 0", m_valid); end
    tick;                                   // n+6: HOLD
    outputValid = 1'b0;
    compared++; if (m_valid !== 1'b1) begin mismatched++; $display("FAIL single_mv_hold got %b want 1", m_valid); end
    compared++; if (m_data !== 38'h19) begin mismatched++; $display("FAIL single_m_data got %h want 19", m_data); end
    compared++; if (sample_count !== 32'd0) begin mismatched++; $display("FAIL single_cnt_hold got %0d want 0", sample_count); end
    tick;                                   // IDLE
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL single_mv_done got %b want 0", m_valid); end
    compared++; if (sample_count !== 32'd1) begin mismatched++; $display("FAIL single_cnt got %0d want 1", sample_count); end
  endtask

  task automatic test_stray;
    outputValid = 1'b1; FIR_output = 38'h2A;
    tick;
    outputValid = 1'b0;
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL stray_m_valid got %b want 0", m_valid); end
    compared++; if (m_data !== 38'h19) begin mismatched++; $display("FAIL stray_m_data got %h want 19", m_data); end
    tick;
    compared++; if (sample_count !== 32'd1) begin mismatched++; $display("FAIL stray_cnt got %0d want 1", sample_count); end
  endtask

  task automatic test_backpressure;
    m_ready = 1'b0;
    s_data = 16'h000A; s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
    tick;                                   // ISSUE
    compared++; if (inputValid !== 1'b1) begin mismatched++; $display("FAIL bp_iv got %b want 1", inputValid); end
    compared++; if (FIR_input !== 16'h000A) begin mismatched++; $display("FAIL bp_fir_input got %h want 000a", FIR_input); end
    tick;                                   // WAIT
    outputValid = 1'b1; FIR_output = 38'h3000000001;
    tick;                                   // HOLD
    outputValid = 1'b0;
    s_data = 16'h000B; s_valid = 1'b1;      // queued while held
    for (int i = 0; i < 10; i++) begin
      compared++; if (m_valid !== 1'b1) begin mismatched++; $display("FAIL bp_m_valid[%0d] got %b want 1", i, m_valid); end
      compared++; if (m_data !== 38'h3000000001) begin mismatched++; $display("FAIL bp_m_data[%0d] got %h want 3000000001", i, m_data); end
      compared++; if (inputValid !== 1'b0) begin mismatched++; $display("FAIL bp_iv_hold[%0d] got %b want 0", i, inputValid); end
      tick;
      s_valid = 1'b0;
    end
    compared++; if (m_valid !== 1'b1) begin mismatched++; $display("FAIL bp_m_valid_end got %b want 1", m_valid); end
    m_ready = 1'b1;
    tick;                                   // IDLE
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL bp_m_valid_rel got %b want 0", m_valid); end
    compared++; if (sample_count !== 32'd2) begin mismatched++; $display("FAIL bp_cnt got %0d want 2", sample_count); end
    compared++; if (inputValid !== 1'b0) begin mismatched++; $display("FAIL bp_iv_idle got %b want 0", inputValid); end
    tick;                                   // ISSUE of queued sample
    compared++; if (inputValid !== 1'b1) begin mismatched++; $display("FAIL bp_iv2 got %b want 1", inputValid); end
    compared++; if (FIR_input !== 16'h000B) begin mismatched++; $display("FAIL bp_fir_input2 got %h want 000b", FIR_input); end
    tick;
    outputValid = 1'b1; FIR_output = 38'h77;
    tick;                                   // HOLD
    outputValid = 1'b0;
    compared++; if (m_data !== 38'h77) begin mismatched++; $display("FAIL bp_m_data2 got %h want 77", m_data); end
    tick;
    compared++; if (sample_count !== 32'd3) begin mismatched++; $display("FAIL bp_cnt2 got %0d want 3", sample_count); end
  endtask

  // Result arriving in the 64th (last) WAIT cycle must be captured.
  task automatic test_timeout_boundary;
    m_ready = 1'b1;
    s_data = 16'h0021; s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
    tick;                                   // ISSUE
    compared++; if (inputValid !== 1'b1) begin mismatched++; $display("FAIL tb_iv got %b want 1", inputValid); end
    for (int i = 1; i <= 64; i++) tick;     // WAIT cycle 64
    outputValid = 1'b1; FIR_output = 38'h55;
    tick;
    outputValid = 1'b0;
    compared++; if (m_valid !== 1'b1) begin mismatched++; $display("FAIL tb_m_valid got %b want 1", m_valid); end
    compared++; if (m_data !== 38'h55) begin mismatched++; $display("FAIL tb_m_data got %h want 55", m_data); end
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL tb_timeout_err got %b want 0", timeout_err); end
    tick;
    compared++; if (sample_count !== 32'd4) begin mismatched++; $display("FAIL tb_cnt got %0d want 4", sample_count); end
  endtask

  task automatic test_timeout;
    s_data = 16'h0031; s_valid = 1'b1;
    tick;
    s_data = 16'h0032;
    tick;
    s_valid = 1'b0;                         // ISSUE of 0x31
    compared++; if (FIR_input !== 16'h0031) begin mismatched++; $display("FAIL to_fir_input got %h want 0031", FIR_input); end
    for (int i = 1; i <= 64; i++) tick;     // WAIT cycle 64, no result
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL to_err_early got %b want 0", timeout_err); end
    tick;                                   // IDLE
    compared++; if (timeout_err !== 1'b1) begin mismatched++; $display("FAIL to_err got %b want 1", timeout_err); end
    compared++; if (inputValid !== 1'b0) begin mismatched++; $display("FAIL to_iv_idle got %b want 0", inputValid); end
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL to_m_valid got %b want 0", m_valid); end
    tick;                                   // ISSUE of 0x32
    compared++; if (inputValid !== 1'b1) begin mismatched++; $display("FAIL to_iv_next got %b want 1", inputValid); end
    compared++; if (FIR_input !== 16'h0032) begin mismatched++; $display("FAIL to_fir_input2 got %h want 0032", FIR_input); end
    compared++; if (sample_count !== 32'd4) begin mismatched++; $display("FAIL to_cnt got %0d want 4", sample_count); end
    tick; tick;                             // 0x32 outstanding in WAIT
    compared++; if (timeout_err !== 1'b1) begin mismatched++; $display("FAIL to_err_sticky got %b want 1", timeout_err); end
  endtask

  task automatic test_async_reset;
    s_data = 16'h0041; s_valid = 1'b1;
    tick;
    s_data = 16'h0042;
    tick;
    s_valid = 1'b0;
    #3;                                     // mid-cycle, well before next edge
    rst = 1'b1;
    #1;
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL ar_s_ready got %b want 1", s_ready); end
    compared++; if (inputValid !== 1'b0) begin mismatched++; $display("FAIL ar_inputValid got %b want 0", inputValid); end
    compared++; if (FIR_input !== 16'h0) begin mismatched++; $display("FAIL ar_FIR_input got %h want 0", FIR_input); end
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL ar_m_valid got %b want 0", m_valid); end
    compared++; if (m_data !== 38'h0) begin mismatched++; $display("FAIL ar_m_data got %h want 0", m_data); end
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL ar_timeout_err got %b want 0", timeout_err); end
    compared++; if (sample_count !== 32'd0) begin mismatched++; $display("FAIL ar_sample_count got %0d want 0", sample_count); end
    tick;
    rst = 1'b0;
    outputValid = 1'b1; FIR_output = 38'h99;  // late result
    tick;
    outputValid = 1'b0;
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL ar_late_m_valid got %b want 0", m_valid); end
    compared++; if (m_data !== 38'h0) begin mismatched++; $display("FAIL ar_late_m_data got %h want 0", m_data); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (inputValid !== 1'b0) begin mismatched++; $display("FAIL ar_discard_iv[%0d] got %b want 0", i, inputValid); end
      tick;
    end
  endtask

  task automatic test_full;
    int waited;
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_data = 16'h0100 + 16'(i); s_valid = 1'b1;
      compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL full_s_ready_push[%0d] got %b want 1", i, s_ready); end
      tick;
    end
    s_data = 16'h01FF;                      // offered but must be refused
    compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL full_s_ready got %b want 0", s_ready); end
    compared++; if (FIR_input !== 16'h0100) begin mismatched++; $display("FAIL full_fir_input got %h want 0100", FIR_input); end
    for (int i = 0; i < 3; i++) begin
      tick;
      compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL full_s_ready_hold[%0d] got %b want 0", i, s_ready); end
    end
    s_valid = 1'b0;
    waited = 0;
    while (inputValid !== 1'b1 && waited < 100) begin
      tick;
      waited++;
    end
    compared++; if (inputValid !== 1'b1) begin mismatched++; $display("FAIL full_reissue got %b want 1 within 100 cycles", inputValid); end
    compared++; if (FIR_input !== 16'h0101) begin mismatched++; $display("FAIL full_fir_input2 got %h want 0101", FIR_input); end
    compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL full_s_ready_issue got %b want 0", s_ready); end
    tick;
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL full_s_ready_pop got %b want 1", s_ready); end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset;
    test_single;
    test_stray;
    test_backpressure;
    test_timeout_boundary;
    test_timeout;
    test_async_reset;
    test_full;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t want completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
